mau_loader: RTL and testbench

MAU_LOADER -- requirements
Module: mau_loader

---
 rtl/mau_pkg.sv | 50 +++++
 rtl/mau_shreg.sv | 32 +++
 rtl/mau_loader.sv | 206 ++++++++++++++++++++
 tb/tb_mau_loader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mau_pkg.sv
// mau_pkg: shared definitions for the MAU loader.
// Holds the FSM state encoding, target select, host opcodes and
// response codes, plus small opcode-decoding helpers.
package mau_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    WRITE,
    RWAIT,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    TGT_NONE = 2'd0,
    TGT_IM   = 2'd1,
    TGT_DM   = 2'd2,
    TGT_RF   = 2'd3
  } target_t;

  localparam logic [7:0] OP_WR_IM  = 8'h01;
  localparam logic [7:0] OP_WR_DM  = 8'h02;
  localparam logic [7:0] OP_WR_RF  = 8'h03;
  localparam logic [7:0] OP_RD_IM  = 8'h11;
  localparam logic [7:0] OP_RD_DM  = 8'h12;
  localparam logic [7:0] OP_RD_RF  = 8'h13;
  localparam logic [7:0] OP_RUN    = 8'h20;
  localparam logic [7:0] OP_STOP   = 8'h21;
  localparam logic [7:0] OP_STATUS = 8'h30;

  localparam logic [7:0] RSP_OK      = 8'hAA;
  localparam logic [7:0] RSP_UNKNOWN = 8'h55;
  localparam logic [7:0] RSP_BUSY    = 8'hEE;

  function automatic logic is_write_op(input logic [7:0] op);
    return (op == OP_WR_IM) || (op == OP_WR_DM) || (op == OP_WR_RF);
  endfunction

  function automatic logic is_mem_op(input logic [7:0] op);
    return is_write_op(op) || (op == OP_RD_IM) || (op == OP_RD_DM) ||
           (op == OP_RD_RF);
  endfunction

  // Low two opcode bits name the target for every memory opcode.
  function automatic target_t op_target(input logic [7:0] op);
    return target_t'(op[1:0]);
  endfunction

endpackage

// File: rtl/mau_shreg.sv
// mau_shreg: 32-bit byte assembly / disassembly register.
//   clk, rst_n   clock, async active-low reset (clears q)
//   shift_in     shift din into the low byte (MSB-first assembly)
//   shift_out    shift left by one byte, zero fill (MSB-first emission)
//   load         parallel load of load_data (highest priority)
//   din          incoming byte
//   load_data    parallel word
//   q            register contents; q[31:24] is the next byte out
module mau_shreg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        shift_in,
  input  logic        shift_out,
  input  logic        load,
  input  logic [7:0]  din,
  input  logic [31:0] load_data,
  output logic [31:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift_in) begin
      q <= {q[23:0], din};
    end else if (shift_out) begin
      q <= {q[23:0], 8'h00};
    end
  end

endmodule

// File: rtl/mau_loader.sv
// mau_loader: byte-stream host loader for the IM/DM/RF memory access units.
//   clk, rst_n            clock, async active-low reset
//   cmd_data/valid/ready  host command byte stream
//   rsp_data/valid/ready  response byte stream
//   mau_address_*         target address (same value on all three)
//   mau_write_data_*      write word (same value on all three)
//   mau_wren_*            one-cycle write strobe per target
//   mau_read_data_*       read words, valid READ_LAT cycles after address
//   alive                 CPU run enable; loader owns MAU ports when 0
//   halt                  CPU halt status, reported by STATUS
module mau_loader
  import mau_pkg::*;
#(
  parameter int unsigned READ_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  cmd_data,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic [7:0]  rsp_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] mau_address_im,
  output logic [31:0] mau_address_dm,
  output logic [31:0] mau_address_rf,
  output logic [31:0] mau_write_data_im,
  output logic [31:0] mau_write_data_dm,
  output logic [31:0] mau_write_data_rf,
  output logic        mau_wren_im,
  output logic        mau_wren_dm,
  output logic        mau_wren_rf,
  input  logic [31:0] mau_read_data_im,
  input  logic [31:0] mau_read_data_dm,
  input  logic [31:0] mau_read_data_rf,
  output logic        alive,
  input  logic        halt
);

  state_t      state, state_n;
  logic [1:0]  cnt, cnt_n;
  logic [2:0]  wait_cnt, wait_n;
  logic        alive_q, alive_n;
  logic        run_q;
  logic [7:0]  op_q, op_n;
  logic [31:0] addr_q, addr_n;
  logic [31:0] wdata_q, wdata_n;
  logic        sh_in, sh_out, sh_load;
  logic [31:0] sh_load_data, sh_q;
  logic        cmd_fire, rsp_fire;
  logic [31:0] rd_sel;
  target_t     tgt;

  mau_shreg u_shreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .shift_in  (sh_in),
    .shift_out (sh_out),
    .load      (sh_load),
    .din       (cmd_data),
    .load_data (sh_load_data),
    .q         (sh_q)
  );

  // run_q keeps the handshakes quiet while reset is asserted even though
  // the state register already reads IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      wait_cnt <= '0;
      alive_q  <= 1'b0;
      run_q    <= 1'b0;
      op_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      wait_cnt <= wait_n;
      alive_q  <= alive_n;
      run_q    <= 1'b1;
      op_q     <= op_n;
      addr_q   <= addr_n;
      wdata_q  <= wdata_n;
    end
  end

  assign tgt = op_target(op_q);

  always_comb begin
    rd_sel = '0;
    case (tgt)
      TGT_IM:  rd_sel = mau_read_data_im;
      TGT_DM:  rd_sel = mau_read_data_dm;
      TGT_RF:  rd_sel = mau_read_data_rf;
      default: rd_sel = '0;
    endcase
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    wait_n       = wait_cnt;
    alive_n      = alive_q;
    op_n         = op_q;
    addr_n       = addr_q;
    wdata_n      = wdata_q;
    sh_in        = 1'b0;
    sh_out       = 1'b0;
    sh_load      = 1'b0;
    sh_load_data = {RSP_OK, 24'h0};
    cmd_ready    = run_q && (state == IDLE || state == ADDR || state == WDATA);
    rsp_valid    = run_q && (state == RESP);
    cmd_fire     = cmd_valid && cmd_ready;
    rsp_fire     = rsp_valid && rsp_ready;

    case (state)
      IDLE: if (cmd_fire) begin
        op_n  = cmd_data;
        cnt_n = '0;
        if (is_mem_op(cmd_data)) begin
          state_n = ADDR;
        end else begin
          state_n = RESP;
          sh_load = 1'b1;
          case (cmd_data)
            OP_RUN:    alive_n = 1'b1;
            OP_STOP:   alive_n = 1'b0;
            OP_STATUS: sh_load_data = {6'b0, alive_q, halt, 24'h0};
            default:   sh_load_data = {RSP_UNKNOWN, 24'h0};
          endcase
        end
      end
      ADDR: if (cmd_fire) begin
        sh_in = 1'b1;
        cnt_n = cnt + 2'd1;
        if (cnt == 2'd3) begin
          // While the CPU runs the frame is drained but the ports untouched.
          if (!alive_q) addr_n = {sh_q[23:0], cmd_data};
          if (is_write_op(op_q)) begin
            state_n = WDATA;
          end else if (alive_q) begin
            state_n      = RESP;
            sh_load      = 1'b1;
            sh_load_data = {RSP_BUSY, 24'h0};
          end else begin
            state_n = RWAIT;
            wait_n  = '0;
          end
        end
      end
      WDATA: if (cmd_fire) begin
        sh_in = 1'b1;
        cnt_n = cnt + 2'd1;
        if (cnt == 2'd3) begin
          if (alive_q) begin
            state_n      = RESP;
            sh_load      = 1'b1;
            sh_load_data = {RSP_BUSY, 24'h0};
          end else begin
            wdata_n = {sh_q[23:0], cmd_data};
            state_n = WRITE;
          end
        end
      end
      WRITE: begin
        sh_load = 1'b1;
        cnt_n   = '0;
        state_n = RESP;
      end
      RWAIT: begin
        if (wait_cnt == 3'(READ_LAT - 1)) begin
          sh_load      = 1'b1;
          sh_load_data = rd_sel;
          cnt_n        = 2'd3;
          state_n      = RESP;
        end else begin
          wait_n = wait_cnt + 3'd1;
        end
      end
      RESP: if (rsp_fire) begin
        if (cnt == 2'd0) begin
          state_n = IDLE;
        end else begin
          sh_out = 1'b1;
          cnt_n  = cnt - 2'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign rsp_data          = (state == RESP) ? sh_q[31:24] : '0;
  assign alive             = alive_q;
  assign mau_address_im    = addr_q;
  assign mau_address_dm    = addr_q;
  assign mau_address_rf    = addr_q;
  assign mau_write_data_im = wdata_q;
  assign mau_write_data_dm = wdata_q;
  assign mau_write_data_rf = wdata_q;
  assign mau_wren_im       = (state == WRITE) && !alive_q && (tgt == TGT_IM);
  assign mau_wren_dm       = (state == WRITE) && !alive_q && (tgt == TGT_DM);
  assign mau_wren_rf       = (state == WRITE) && !alive_q && (tgt == TGT_RF);

endmodule

// File: tb/tb_mau_loader.sv
// tb_mau_loader: directed self-checking bench for mau_loader.
// Instance 0 uses READ_LAT=2, instance 1 uses READ_LAT=5; each has its own
// small latency-accurate memory model on the MAU ports.
module tb_mau_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       halt;
  logic [7:0] cmd_data;

  logic        cmd_valid [2];
  logic        cmd_ready [2];
  logic [7:0]  rsp_data  [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] a_im [2], a_dm [2], a_rf [2];
  logic [31:0] wd_im [2], wd_dm [2], wd_rf [2];
  logic [31:0] rd_im [2], rd_dm [2], rd_rf [2];
  logic        we_im [2], we_dm [2], we_rf [2];
  logic        alive [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mau_loader #(.READ_LAT(2)) u0 (
    .clk(clk), .rst_n(rst_n), .cmd_data(cmd_data), .cmd_valid(cmd_valid[0]),
    .cmd_ready(cmd_ready[0]), .rsp_data(rsp_data[0]), .rsp_valid(rsp_valid[0]),
    .rsp_ready(rsp_ready[0]), .mau_address_im(a_im[0]), .mau_address_dm(a_dm[0]),
    .mau_address_rf(a_rf[0]), .mau_write_data_im(wd_im[0]),
    .mau_write_data_dm(wd_dm[0]), .mau_write_data_rf(wd_rf[0]),
    .mau_wren_im(we_im[0]), .mau_wren_dm(we_dm[0]), .mau_wren_rf(we_rf[0]),
    .mau_read_data_im(rd_im[0]), .mau_read_data_dm(rd_dm[0]),
    .mau_read_data_rf(rd_rf[0]), .alive(alive[0]), .halt(halt)
  );

  mau_loader #(.READ_LAT(5)) u1 (
    .clk(clk), .rst_n(rst_n), .cmd_data(cmd_data), .cmd_valid(cmd_valid[1]),
    .cmd_ready(cmd_ready[1]), .rsp_data(rsp_data[1]), .rsp_valid(rsp_valid[1]),
    .rsp_ready(rsp_ready[1]), .mau_address_im(a_im[1]), .mau_address_dm(a_dm[1]),
    .mau_address_rf(a_rf[1]), .mau_write_data_im(wd_im[1]),
    .mau_write_data_dm(wd_dm[1]), .mau_write_data_rf(wd_rf[1]),
    .mau_wren_im(we_im[1]), .mau_wren_dm(we_dm[1]), .mau_wren_rf(we_rf[1]),
    .mau_read_data_im(rd_im[1]), .mau_read_data_dm(rd_dm[1]),
    .mau_read_data_rf(rd_rf[1]), .alive(alive[1]), .halt(halt)
  );

  // Memory model: read data in cycle t reflects the address of cycle
  // t-(LAT-1); hist[k][j] is the address from j+1 cycles ago.
  logic [31:0] hist [2][8];
  logic [31:0] m_im [2][16];
  logic [31:0] m_dm [2][16];
  logic [31:0] m_rf [2][16];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      for (int j = 7; j > 0; j--) hist[k][j] <= hist[k][j-1];
      hist[k][0] <= a_dm[k];
      if (we_im[k]) m_im[k][a_im[k][3:0]] <= wd_im[k];
      if (we_dm[k]) m_dm[k][a_dm[k][3:0]] <= wd_dm[k];
      if (we_rf[k]) m_rf[k][a_rf[k][3:0]] <= wd_rf[k];
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      logic [31:0] ra;
      ra = (k == 0) ? hist[k][0] : hist[k][3];
      rd_im[k] = m_im[k][ra[3:0]];
      rd_dm[k] = m_dm[k][ra[3:0]];
      rd_rf[k] = m_rf[k][ra[3:0]];
    end
  end

  // Write strobe observation, sampled away from the active edge.
  int          n_im [2] = '{0, 0};
  int          n_dm [2] = '{0, 0};
  int          n_rf [2] = '{0, 0};
  logic [31:0] w_addr [2];
  logic [31:0] w_data [2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (we_im[k]) begin n_im[k]++; w_addr[k] = a_im[k]; w_data[k] = wd_im[k]; end
      if (we_dm[k]) begin n_dm[k]++; w_addr[k] = a_dm[k]; w_data[k] = wd_dm[k]; end
      if (we_rf[k]) begin n_rf[k]++; w_addr[k] = a_rf[k]; w_data[k] = wd_rf[k]; end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input int k, input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    cmd_data     = b;
    cmd_valid[k] = 1'b1;
    while (!cmd_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("cmd_ready_timeout", 32'(cmd_ready[k]), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid[k] = 1'b0;
  endtask

  task automatic send_frame(input int k, input logic [71:0] f, input int n);
    for (int i = 0; i < n; i++) send_byte(k, f[8*(n-1-i) +: 8]);
  endtask

  task automatic expect_rsp(input int k, input string tag, input logic [31:0] exp, input int n);
    for (int i = 0; i < n; i++) begin
      int c = 0;
      logic [7:0] b;
      @(negedge clk);
      rsp_ready[k] = 1'b1;
      while (!rsp_valid[k] && c < 100) begin
        @(negedge clk);
        c++;
      end
      if (c >= 100) check($sformatf("%s_timeout%0d", tag, i), 32'(rsp_valid[k]), 32'd1);
      b = rsp_data[k];
      check($sformatf("%s_b%0d", tag, i), 32'(b), 32'(exp[8*(n-1-i) +: 8]));
      @(posedge clk);
      #1;
      rsp_ready[k] = 1'b0;
    end
  endtask

  initial begin
    int          s_im, s_dm, s_rf, c;
    logic [7:0]  first;
    logic        stable;

    rst_n = 1'b0;
    halt  = 1'b0;
    cmd_data = '0;
    for (int k = 0; k < 2; k++) begin
      cmd_valid[k] = 1'b0;
      rsp_ready[k] = 1'b0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready[0]), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check("rst_rsp_data", 32'(rsp_data[0]), 32'h00);
    check("rst_alive", 32'(alive[0]), 32'd0);
    check("rst_wren", 32'({we_im[0], we_dm[0], we_rf[0]}), 32'd0);
    check("rst_addr", a_dm[0], 32'h0);
    check("rst_wdata", wd_rf[0], 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_cmd_ready", 32'(cmd_ready[0]), 32'd1);

    // IM write
    s_im = n_im[0]; s_dm = n_dm[0]; s_rf = n_rf[0];
    send_frame(0, 72'h01_00000004_DEADBEEF, 9);
    expect_rsp(0, "wr_im_rsp", 32'hAA, 1);
    check("wr_im_pulses", 32'(n_im[0] - s_im), 32'd1);
    check("wr_im_other", 32'((n_dm[0] - s_dm) + (n_rf[0] - s_rf)), 32'd0);
    check("wr_im_addr", w_addr[0], 32'h4);
    check("wr_im_data", w_data[0], 32'hDEADBEEF);

    // DM write then read back on both latencies
    for (int k = 0; k < 2; k++) begin
      send_frame(k, 72'h02_00000008_12345678, 9);
      expect_rsp(k, $sformatf("wr_dm%0d_rsp", k), 32'hAA, 1);
      send_frame(k, 72'h12_00000008, 5);
      expect_rsp(k, $sformatf("rd_dm%0d", k), 32'h12345678, 4);
    end

    // RUN, then a write while alive is refused
    send_frame(0, 72'h20, 1);
    expect_rsp(0, "run_rsp", 32'hAA, 1);
    check("run_alive", 32'(alive[0]), 32'd1);
    s_im = n_im[0]; s_dm = n_dm[0]; s_rf = n_rf[0];
    send_frame(0, 72'h03_00000001_00000007, 9);
    expect_rsp(0, "busy_rsp", 32'hEE, 1);
    check("busy_rf_pulses", 32'(n_rf[0] - s_rf), 32'd0);
    check("busy_any_pulses", 32'((n_im[0] - s_im) + (n_dm[0] - s_dm)), 32'd0);

    // STATUS / STOP
    halt = 1'b1;
    send_frame(0, 72'h30, 1);
    expect_rsp(0, "status_run", 32'h03, 1);
    send_frame(0, 72'h21, 1);
    expect_rsp(0, "stop_rsp", 32'hAA, 1);
    check("stop_alive", 32'(alive[0]), 32'd0);
    send_frame(0, 72'h30, 1);
    expect_rsp(0, "status_stop", 32'h01, 1);
    halt = 1'b0;

    // Back-pressured IM read: first byte held, no command acceptance
    send_frame(0, 72'h11_00000004, 5);
    c = 0;
    @(negedge clk);
    while (!rsp_valid[0] && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("stall_valid", 32'(rsp_valid[0]), 32'd1);
    first  = rsp_data[0];
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (rsp_data[0] !== first || cmd_ready[0] !== 1'b0 || rsp_valid[0] !== 1'b1)
        stable = 1'b0;
    end
    check("stall_stable", 32'(stable), 32'd1);
    expect_rsp(0, "stall_rd", 32'hDEADBEEF, 4);
    send_frame(0, 72'h7F, 1);
    expect_rsp(0, "unknown_rsp", 32'h55, 1);

    // Reset mid-frame
    send_frame(0, 72'h20, 1);
    expect_rsp(0, "run2_rsp", 32'hAA, 1);
    send_frame(0, 72'h01_000000, 4);
    s_im = n_im[0]; s_dm = n_dm[0]; s_rf = n_rf[0];
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("midrst_alive", 32'(alive[0]), 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check("midrst_wren", 32'((n_im[0] - s_im) + (n_dm[0] - s_dm) + (n_rf[0] - s_rf)), 32'd0);
    send_frame(0, 72'h02_0000000C_0BADF00D, 9);
    expect_rsp(0, "post_rst_wr", 32'hAA, 1);
    check("post_rst_dm_pulses", 32'(n_dm[0] - s_dm), 32'd1);
    check("post_rst_addr", w_addr[0], 32'hC);
    check("post_rst_data", w_data[0], 32'h0BADF00D);
    send_frame(0, 72'h12_0000000C, 5);
    expect_rsp(0, "post_rst_rd", 32'h0BADF00D, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
